// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO read-side engine.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package fifo_reader_pkg;

  // Read engine control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_SKID_DEPTH = 2;
  localparam int DEF_CNT_WIDTH  = 16;

  // Pointer width for a circular buffer of 'depth' entries; never below 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Circular skid buffer that holds words captured from the FIFO read port.
// Latency: a pushed word is visible at head_data the cycle after the push.
// Backpressure: pop on empty is ignored; push when full is dropped and flagged by an assertion.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = DEF_FIFO_WIDTH,
  parameter int DEPTH = DEF_SKID_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (occupancy != '0);
  assign do_push   = push && (occupancy != OCC_W'(DEPTH));
  assign head_data = mem[head];

  // Storage array; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[tail] <= push_data;
    end
  end

  // Head/tail pointers and occupancy; push and pop together keep occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        tail <= ptr_inc(tail);
      end
      if (do_pop) begin
        head <= ptr_inc(head);
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // The read issue logic reserves a slot per outstanding read, so a full push is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (occupancy < OCC_W'(DEPTH)));

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from the synchronous FIFO read port and presents them as a valid/ready stream.
// Latency: first word valid 2 cycles after the first fifo_rd_en; 1 word/cycle sustained.
// Backpressure: reads are issued only while skid occupancy plus outstanding read leaves a free slot.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  err_underflow,
  input  logic                  err_clr
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int PND_W = OCC_W + 1;

  state_e           state;
  state_e           state_nxt;
  logic             inflight;
  logic             pop;
  logic             push;
  logic [OCC_W-1:0] occupancy;
  logic [PND_W-1:0] pending;

  // Words that will sit in the skid buffer after this cycle if no new read is issued.
  assign pop        = out_valid && out_ready;
  assign pending    = {1'b0, occupancy} + PND_W'(inflight) - PND_W'(pop);
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (pending < PND_W'(SKID_DEPTH));

  // A read that came back flagged as underflow carries no data and is not captured.
  assign push      = inflight && !fifo_underflow;
  assign out_valid = (occupancy != '0);
  assign busy      = (state != IDLE) || inflight || (occupancy != '0);

  fifo_reader_skid #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (out_data),
    .occupancy (occupancy)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: DRAIN waits for the outstanding read before returning to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (!inflight) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-cycle FIFO read latency: data for a read issued now arrives next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Delivered-word counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  // Sticky underflow flag; a new underflow in the same cycle beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end else if (err_clr) begin
      err_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: behavioural FIFO model, scoreboard of expected words.
// Latency: n/a.
// Backpressure: out_ready driven by the stimulus sequence.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_underflow = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] word_count;
  logic        err_underflow;
  logic        err_clr = 1'b0;

  // Twin with a 4-bit counter, fed the same stimulus, for wrap checks.
  logic        rd_en4;
  logic [15:0] out_data4;
  logic        out_valid4;
  logic        busy4;
  logic [3:0]  word_count4;
  logic        err_underflow4;

  fifo_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .word_count(word_count),
    .err_underflow(err_underflow), .err_clr(err_clr)
  );

  fifo_reader #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(rd_en4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .busy(busy4), .word_count(word_count4),
    .err_underflow(err_underflow4), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered read data and underflow; written only by the stimulus process.
  logic [15:0] fmem [64];
  int          wr_p = 0;
  int          rd_p = 0;
  logic        force_nonempty = 1'b0;
  logic [15:0] sb [$];

  assign fifo_empty = force_nonempty ? 1'b0 : (wr_p == rd_p);

  // Read port of the modelled FIFO; reset flushes whatever is left.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p           <= wr_p;
      fifo_underflow <= 1'b0;
      fifo_data_out  <= '0;
    end else begin
      fifo_underflow <= 1'b0;
      if (fifo_rd_en) begin
        if (wr_p != rd_p) begin
          fifo_data_out <= fmem[rd_p % 64];
          rd_p          <= rd_p + 1;
        end else begin
          fifo_underflow <= 1'b1;
        end
      end
    end
  end

  // Output monitor: scoreboard compare on every pop, hold-stability while stalled.
  int          rd_cnt = 0;
  int          pop_cnt = 0;
  int          last_pop = 0;
  logic [15:0] exp_cnt = '0;
  logic [3:0]  exp_cnt4 = '0;
  logic        hold_pend = 1'b0;
  logic [15:0] held_data = '0;
  logic [15:0] exp_word;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_cnt   = '0;
      exp_cnt4  = '0;
      hold_pend = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (hold_pend) check_eq("hold_data", out_data, held_data);
      if (out_valid && out_ready) begin
        pop_cnt++;
        last_pop = cyc;
        if (sb.size() == 0) begin
          check_eq("pop_with_sb_empty", {31'b0, out_valid}, 32'd0);
        end else begin
          exp_word = sb.pop_front();
          check_eq("data", out_data, exp_word);
        end
        check_eq("word_count", word_count, exp_cnt);
        check_eq("word_count4", word_count4, exp_cnt4);
        exp_cnt  = exp_cnt + 16'd1;
        exp_cnt4 = exp_cnt4 + 4'd1;
      end
      hold_pend = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_p % 64] = base + 16'(i);
      sb.push_back(base + 16'(i));
      wr_p++;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check_eq(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int t_en, t_rd, t_v, t_rel, c0, p0;

  initial begin
    // Reset state
    tick(2);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_word_count", word_count, 0);
    check_eq("rst_err", err_underflow, 0);
    check_eq("rst_out_data", out_data, 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // 1: straight stream of 8 words with consumer always ready
    preload(16'h0001, 8);
    out_ready = 1'b1;
    enable = 1'b1;
    t_en = cyc;
    c0 = rd_cnt;
    t_rd = -1;
    t_v = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_rd_en && t_rd < 0) t_rd = cyc;
      if (out_valid && t_v < 0) begin
        t_v = cyc;
        break;
      end
    end
    check_eq("issue_latency", t_rd - t_en, 1);
    check_eq("valid_after_issue", t_v - t_rd, 2);
    wait_drain("t1_drain", 40);
    check_eq("t1_rd_pulses", rd_cnt - c0, 8);
    check_eq("t1_pop_span", last_pop - t_v, 7);
    check_eq("t1_word_count", word_count, 8);
    tick(1);
    enable = 1'b0;
    tick(3);
    @(negedge clk);
    check_eq("t1_busy_idle", busy, 0);

    // 2: stalled consumer fills the skid buffer, then releases
    tick(1);
    preload(16'h0001, 8);
    out_ready = 1'b0;
    enable = 1'b1;
    c0 = rd_cnt;
    repeat (6) @(negedge clk);
    check_eq("t2_rd_pulses", rd_cnt - c0, 2);
    check_eq("t2_valid", out_valid, 1);
    check_eq("t2_head", out_data, 16'h0001);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t_rel = cyc;
    p0 = pop_cnt;
    wait_drain("t2_drain", 40);
    check_eq("t2_pops", pop_cnt - p0, 8);
    check_eq("t2_no_gap", last_pop - t_rel, 7);
    tick(1);
    enable = 1'b0;
    tick(3);

    // 3: FIFO reports non-empty but the read underflows
    force_nonempty = 1'b1;
    enable = 1'b1;
    c0 = rd_cnt;
    p0 = pop_cnt;
    tick(1);
    enable = 1'b0;
    tick(1);
    force_nonempty = 1'b0;
    tick(1);
    @(negedge clk);
    check_eq("t3_rd_pulses", rd_cnt - c0, 1);
    check_eq("t3_err_set", err_underflow, 1);
    tick(3);
    @(negedge clk);
    check_eq("t3_err_sticky", err_underflow, 1);
    check_eq("t3_no_capture", pop_cnt - p0, 0);
    check_eq("t3_word_count", word_count, 16);
    tick(1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    @(negedge clk);
    check_eq("t3_err_clr", err_underflow, 0);

    // 4: enable dropped for 3 cycles mid-stream
    tick(1);
    preload(16'h0101, 8);
    enable = 1'b1;
    tick(5);
    enable = 1'b0;
    tick(1);
    @(negedge clk);
    check_eq("t4_drain_rd_a", fifo_rd_en, 0);
    tick(1);
    @(negedge clk);
    check_eq("t4_drain_rd_b", fifo_rd_en, 0);
    tick(1);
    enable = 1'b1;
    @(negedge clk);
    check_eq("t4_idle_rd", fifo_rd_en, 0);
    check_eq("t4_idle_busy", busy, 0);
    wait_drain("t4_drain", 40);
    check_eq("t4_word_count", word_count, 24);
    tick(1);
    enable = 1'b0;
    tick(3);

    // 5: reset with one word buffered and one read outstanding
    preload(16'h0201, 8);
    out_ready = 1'b0;
    enable = 1'b1;
    c0 = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_cnt - c0 >= 2) break;
    end
    check_eq("t5_two_reads", rd_cnt - c0, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", out_valid, 0);
    check_eq("t5_rst_count", word_count, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_rd_en", fifo_rd_en, 0);
    sb.delete();
    enable = 1'b0;
    out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t5_no_ghost", out_valid, 0);
    end

    // 6: 18 words so the 4-bit counter wraps
    tick(1);
    preload(16'h0300, 18);
    enable = 1'b1;
    wait_drain("t6_drain", 80);
    check_eq("t6_word_count", word_count, 18);
    check_eq("t6_word_count4", word_count4, 2);
    tick(1);
    enable = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
